// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: the state encoding,
// bus widths and the values the memory-write outputs take in reset.
package boot_pkg;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 16;

  localparam logic              MEM_WE_RST   = 1'b0;
  localparam logic [ADDR_W-1:0] MEM_ADDR_RST = '0;
  localparam logic [WORD_W-1:0] MEM_IN_RST   = '0;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DAT_HI = 3'd2,
    DAT_LO = 3'd3,
    CHK_HI = 3'd4,
    CHK_LO = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } boot_state_t;

  // States in which the loader is still consuming bytes from the source.
  function automatic logic is_receiving(input boot_state_t s);
    return s inside {HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO};
  endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Pairs accepted bytes into big-endian 16-bit words. The high byte is held
// in a register; the word is presented together with the low byte so the
// loader can act on the same edge that accepts the low byte.
module boot_word_asm
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [7:0]        data,
  input  logic              valid,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic       lo_next;
  logic [7:0] hi_byte;

  // Toggle between high and low byte on every accepted byte; keep the high byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_next <= 1'b0;
      hi_byte <= 8'h00;
    end else if (clear) begin
      lo_next <= 1'b0;
      hi_byte <= 8'h00;
    end else if (valid) begin
      lo_next <= !lo_next;
      if (!lo_next) hi_byte <= data;
    end
  end

  assign word       = {hi_byte, data};
  assign word_valid = valid && lo_next;

endmodule

// File: rtl/boot_loader.sv
// Program loader: receives a length-prefixed big-endian stream of 16-bit
// words, writes them to memory from BASE_ADDR and holds the processor in
// reset until the image is complete.
// Optional feature: define BOOT_CHECKSUM_EN to require a trailing 16-bit
// modulo-2^16 sum of the data words before the processor is released.
module boot_loader
  import boot_pkg::*;
#(
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rxData,
  input  logic              rxValid,
  output logic              rxReady,
  input  logic              restart,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [WORD_W-1:0] memIn,
  output logic              cpuRst,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t AFTER_DATA = CHK_HI;
`else
  localparam boot_state_t AFTER_DATA = DONE;
`endif

  boot_state_t       state;
  boot_state_t       state_next;
  logic [WORD_W-1:0] count;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] index_inc;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              accept;
  logic              restart_take;
  logic              write_now;

  assign accept       = rxValid && rxReady;
  assign restart_take = restart && (state == DONE || state == ERROR);
  assign index_inc    = index + 16'd1;
  assign write_now    = (state == DAT_LO) && word_valid;

  boot_word_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (restart_take),
    .data      (rxData),
    .valid     (accept),
    .word      (word),
    .word_valid(word_valid)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [WORD_W-1:0] sum;

  // Running modulo-2^16 sum of the data words, cleared for every new image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
    end else if (restart_take || (state == HDR_LO && word_valid)) begin
      sum <= '0;
    end else if (write_now) begin
      sum <= sum + word;
    end
  end
`endif

  // Next-state decision from the byte just being accepted.
  always_comb begin
    state_next = state;
    case (state)
      HDR_HI: if (accept) state_next = HDR_LO;
      HDR_LO: begin
        if (word_valid) begin
          if ({16'd0, word} > DEPTH_U)  state_next = ERROR;
          else if (word == '0)          state_next = AFTER_DATA;
          else                          state_next = DAT_HI;
        end
      end
      DAT_HI: if (accept) state_next = DAT_LO;
      DAT_LO: begin
        if (word_valid) state_next = (index_inc == count) ? AFTER_DATA : DAT_HI;
      end
`ifdef BOOT_CHECKSUM_EN
      CHK_HI: if (accept) state_next = CHK_LO;
      CHK_LO: if (word_valid) state_next = (word == sum) ? DONE : ERROR;
`endif
      DONE:   if (restart) state_next = HDR_HI;
      ERROR:  if (restart) state_next = HDR_HI;
      default: state_next = HDR_HI;
    endcase
  end

  // State, image length and word index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HDR_HI;
      count <= '0;
      index <= '0;
    end else begin
      state <= state_next;
      if (restart_take) begin
        index <= '0;
      end else if (state == HDR_LO && word_valid) begin
        count <= word;
        index <= '0;
      end else if (write_now) begin
        index <= index_inc;
      end
    end
  end

  // One-cycle memory write in the cycle after the low byte is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memWe   <= MEM_WE_RST;
      memAddr <= MEM_ADDR_RST;
      memIn   <= MEM_IN_RST;
    end else begin
      memWe <= write_now;
      if (write_now) begin
        memAddr <= BASE_ADDR + index;
        memIn   <= word;
      end
    end
  end

  // Status outputs; the processor is released one cycle after DONE is
  // entered so it never runs ahead of the final write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxReady <= 1'b0;
      cpuRst  <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      rxReady <= is_receiving(state_next);
      cpuRst  <= !(state == DONE && state_next == DONE);
      done    <= (state == DONE && state_next == DONE);
      err     <= (state_next == ERROR);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed and randomized images are
// streamed in, and captured memory writes and status outputs are compared
// with a list-based model of what the image should produce.
// Define BOOT_CHECKSUM_EN to exercise the checksum variant.
module tb_boot_loader;

  localparam int          DEPTH = 1024;
  localparam logic [15:0] BASE  = 16'h0000;

  logic        clk;
  logic        rst;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic        restart;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memIn;
  logic        cpuRst;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [7:0]  txQ[$];
  logic [15:0] imgQ[$];
  logic [31:0] expQ[$];
  logic [31:0] wrQ[$];

  boot_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .rst    (rst),
    .rxData (rxData),
    .rxValid(rxValid),
    .rxReady(rxReady),
    .restart(restart),
    .memWe  (memWe),
    .memAddr(memAddr),
    .memIn  (memIn),
    .cpuRst (cpuRst),
    .done   (done),
    .err    (err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Capture every memory write as {address, data}.
  always @(negedge clk) begin
    if (rst && memWe) wrQ.push_back({memAddr, memIn});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Turn imgQ into a byte stream and the list of writes it must produce.
  task automatic prepare();
`ifdef BOOT_CHECKSUM_EN
    logic [15:0] s = 16'h0000;
`endif
    txQ.delete();
    expQ.delete();
    wrQ.delete();
    txQ.push_back(8'(imgQ.size() >> 8));
    txQ.push_back(8'(imgQ.size()));
    foreach (imgQ[k]) begin
      txQ.push_back(imgQ[k][15:8]);
      txQ.push_back(imgQ[k][7:0]);
      expQ.push_back({16'(BASE + 16'(k)), imgQ[k]});
`ifdef BOOT_CHECKSUM_EN
      s = s + imgQ[k];
`endif
    end
`ifdef BOOT_CHECKSUM_EN
    txQ.push_back(s[15:8]);
    txQ.push_back(s[7:0]);
`endif
  endtask

  // Offer the first 'limit' bytes of txQ; mode 0 back-to-back, 1 toggled, 2 random gaps.
  // Returns on the negedge after the last accepted edge, with rxValid dropped.
  task automatic applyStimulus(input int mode, input int limit);
    int  i = 0;
    int  guard = 0;
    bit  tog = 1'b0;
    bit  offer;
    while (i < limit && guard < 4 * limit + 100) begin
      @(negedge clk);
      guard++;
      if (mode == 1) begin
        tog   = !tog;
        offer = tog;
      end else if (mode == 2) begin
        offer = 1'($urandom_range(0, 1));
      end else begin
        offer = 1'b1;
      end
      if (offer) begin
        rxValid = 1'b1;
        rxData  = txQ[i];
        if (rxReady) i++;
      end else begin
        rxValid = 1'b0;
        rxData  = 8'($urandom);
      end
    end
    check("stream.accepted", 32'(i), 32'(limit));
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic waitEnd(input string tag);
    int n = 0;
    while (!(done || err) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".terminated"}, 32'(done || err), 32'd1);
  endtask

  task automatic checkWrites(input string tag);
    check({tag, ".writes"}, 32'(wrQ.size()), 32'(expQ.size()));
    for (int k = 0; k < expQ.size() && k < wrQ.size(); k++)
      check($sformatf("%s.w%0d", tag, k), wrQ[k], expQ[k]);
  endtask

  task automatic pulseRestart(input string tag);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check({tag, ".cpuRst"}, 32'(cpuRst), 32'd1);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
    check({tag, ".rxReady"}, 32'(rxReady), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, ".rxReady"}, 32'(rxReady), 32'd0);
    check({tag, ".memWe"}, 32'(memWe), 32'd0);
    check({tag, ".memAddr"}, 32'(memAddr), 32'd0);
    check({tag, ".memIn"}, 32'(memIn), 32'd0);
    check({tag, ".cpuRst"}, 32'(cpuRst), 32'd1);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
  endtask

  // Abort guard in case a wait is somehow never satisfied.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst     = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;
    restart = 1'b0;

    // Reset values and first ready edge.
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;
    @(negedge clk);
    check("reset.readyRises", 32'(rxReady), 32'd1);

    // Nominal three-word image, back-to-back.
    imgQ = '{16'h1234, 16'hABCD, 16'h0001};
    prepare();
    applyStimulus(0, txQ.size());
`ifndef BOOT_CHECKSUM_EN
    check("nominal.lastWe", 32'(memWe), 32'd1);
    check("nominal.cpuRstHeld", 32'(cpuRst), 32'd1);
    check("nominal.readyLow", 32'(rxReady), 32'd0);
    @(negedge clk);
    check("nominal.cpuRstFell", 32'(cpuRst), 32'd0);
    check("nominal.weDone", 32'(memWe), 32'd0);
`else
    waitEnd("nominal");
`endif
    check("nominal.done", 32'(done), 32'd1);
    check("nominal.err", 32'(err), 32'd0);
    checkWrites("nominal");

    // Bytes offered while not ready must be ignored.
    wrQ.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rxValid = 1'b1;
      rxData  = 8'($urandom);
    end
    @(negedge clk);
    rxValid = 1'b0;
    check("idle.noWrites", 32'(wrQ.size()), 32'd0);
    check("idle.stillDone", 32'(done), 32'd1);

    pulseRestart("restart1");

    // Zero-length image.
    imgQ.delete();
    prepare();
    applyStimulus(0, txQ.size());
    waitEnd("zero");
    check("zero.done", 32'(done), 32'd1);
    check("zero.err", 32'(err), 32'd0);
    checkWrites("zero");

    pulseRestart("restart2");

    // Oversize count.
    txQ = '{8'h04, 8'h01};
    expQ.delete();
    wrQ.delete();
    applyStimulus(0, txQ.size());
    waitEnd("oversize");
    check("oversize.err", 32'(err), 32'd1);
    check("oversize.cpuRst", 32'(cpuRst), 32'd1);
    check("oversize.done", 32'(done), 32'd0);
    check("oversize.ready", 32'(rxReady), 32'd0);
    checkWrites("oversize");

    pulseRestart("restartErr");

    // Throttled two-word image.
    imgQ = '{16'($urandom), 16'($urandom)};
    prepare();
    applyStimulus(1, txQ.size());
    waitEnd("throttle");
    check("throttle.done", 32'(done), 32'd1);
    checkWrites("throttle");

    pulseRestart("restart3");

    // Reset after the first word, then a fresh image.
    imgQ = '{16'h5555, 16'h6666};
    prepare();
    applyStimulus(0, 4);
    check("midreset.firstWe", 32'(memWe), 32'd1);
    check("midreset.firstAddr", 32'(memAddr), 32'(BASE));
    rst = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    imgQ = '{16'($urandom), 16'($urandom), 16'($urandom)};
    prepare();
    applyStimulus(0, txQ.size());
    waitEnd("fresh");
    check("fresh.done", 32'(done), 32'd1);
    checkWrites("fresh");

    pulseRestart("restart4");

    // Randomized images with random source gaps.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 8);
      imgQ.delete();
      for (int k = 0; k < n; k++) imgQ.push_back(16'($urandom));
      prepare();
      applyStimulus(2, txQ.size());
      waitEnd($sformatf("rand%0d", r));
      check($sformatf("rand%0d.done", r), 32'(done), 32'd1);
      checkWrites($sformatf("rand%0d", r));
      pulseRestart($sformatf("rand%0d.restart", r));
    end

`ifdef BOOT_CHECKSUM_EN
    // Good checksum releases the processor.
    imgQ = '{16'h1234, 16'hABCD};
    prepare();
    check("chk.sumBE01", {txQ[6], txQ[7]}, 32'h0000BE01);
    applyStimulus(0, txQ.size());
    waitEnd("chkGood");
    check("chkGood.done", 32'(done), 32'd1);
    check("chkGood.err", 32'(err), 32'd0);
    checkWrites("chkGood");
    pulseRestart("chkGood.restart");

    // Bad checksum ends in error with the processor held.
    prepare();
    txQ[7] = 8'h02;
    applyStimulus(0, txQ.size());
    waitEnd("chkBad");
    check("chkBad.err", 32'(err), 32'd1);
    check("chkBad.cpuRst", 32'(cpuRst), 32'd1);
    check("chkBad.done", 32'(done), 32'd0);
    pulseRestart("chkBad.restart");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
